// File: rtl/load_hazard_ctrl.sv
// rtl/load_hazard_ctrl.sv - load-use hazard scoreboard, ID stall/bubble control and stall watchdog
module load_hazard_ctrl #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STALL_TIMEOUT   = 1024,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_rd_we,
    input  logic             id_is_load,
    input  logic             ex_ready,
    input  logic             flush_in,
    input  logic             ld_done_valid,
    input  logic [4:0]       ld_done_rd,
    output logic             stall_out,
    output logic             bubble_out,
    output logic             issue_out,
    output logic [4:0]       outstanding,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             error_out
);

    localparam int          TMR_W = $clog2(STALL_TIMEOUT) + 1;
    localparam logic [4:0]  MAX_O = 5'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      pend;
    logic [4:0]       x0_cnt;
    logic [TMR_W-1:0] timer;

    logic [31:0] done_vec;
    logic [31:0] pend_eff;
    logic        done_hit;
    logic [4:0]  outstanding_eff;
    logic        hazard;
    logic        load_issue;
    logic [31:0] clr_mask;
    logic [31:0] set_mask;

    // Scoreboard view seen by ID: a load completing this cycle is already forwarded
    always_comb begin
        done_vec        = ld_done_valid ? (32'd1 << ld_done_rd) : 32'd0;
        pend_eff        = pend & ~done_vec;
        done_hit        = ld_done_valid & ((ld_done_rd == 5'd0) ? (x0_cnt != 5'd0) : pend[ld_done_rd]);
        outstanding_eff = outstanding - {4'd0, done_hit};
        hazard          = id_valid & ~flush_in &
                          ((id_rs1_used & pend_eff[id_rs1_addr]) |
                           (id_rs2_used & pend_eff[id_rs2_addr]) |
                           (id_rd_we    & pend_eff[id_rd_addr])  |
                           (id_is_load  & (outstanding_eff == MAX_O)));
        load_issue      = issue_out & id_is_load;
        clr_mask        = (done_hit && ld_done_rd != 5'd0) ? done_vec : 32'd0;
        set_mask        = (load_issue && id_rd_addr != 5'd0) ? (32'd1 << id_rd_addr) : 32'd0;
    end

    // Scoreboard update: completion clears first so a same-cycle reissue of that rd stays pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= 32'd0;
            x0_cnt      <= 5'd0;
            outstanding <= 5'd0;
        end else begin
            pend        <= ((pend & ~clr_mask) | set_mask) & ~32'd1;
            x0_cnt      <= x0_cnt + {4'd0, load_issue & (id_rd_addr == 5'd0)}
                                  - {4'd0, done_hit & (ld_done_rd == 5'd0)};
            outstanding <= outstanding + {4'd0, load_issue} - {4'd0, done_hit};
        end
    end

    // Saturating count of cycles spent stalled on a real hazard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (hazard && stall_cycles != {CNT_W{1'b1}}) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Consecutive-stall timer; the first hazard cycle in RUN counts as 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else begin
            case (state)
                RUN:     timer <= hazard ? TMR_W'(1) : '0;
                STALL:   timer <= hazard ? timer + 1'b1 : '0;
                default: timer <= timer;
            endcase
        end
    end

    // Next-state: a hazard held for STALL_TIMEOUT cycles locks into ERR
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (hazard) state_nxt = STALL;
            end
            STALL: begin
                if (!hazard)                                  state_nxt = RUN;
                else if (timer == TMR_W'(STALL_TIMEOUT - 1)) state_nxt = ERR;
            end
            default: state_nxt = ERR;
        endcase
    end

    // Outputs: zero-latency stall, forced quiet while reset is asserted
    always_comb begin
        stall_out  = rst_n & (hazard | (state == ERR));
        bubble_out = stall_out;
        issue_out  = rst_n & id_valid & ex_ready & ~stall_out & ~flush_in;
        error_out  = (state == ERR);
    end

endmodule

// File: tb/tb_load_hazard_ctrl.sv
// tb/tb_load_hazard_ctrl.sv - self-checking bench for load_hazard_ctrl
module tb_load_hazard_ctrl;

    localparam int MAXO = 2;
    localparam int TMO  = 1024;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [4:0]    id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
    logic          id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_rd_we = 1'b0, id_is_load = 1'b0;
    logic          ex_ready = 1'b1, flush_in = 1'b0;
    logic          ld_done_valid = 1'b0;
    logic [4:0]    ld_done_rd = '0;
    logic          stall_out, bubble_out, issue_out, error_out;
    logic [4:0]    outstanding;
    logic [CW-1:0] stall_cycles;

    int n_chk = 0;
    int n_fail = 0;

    load_hazard_ctrl #(.MAX_OUTSTANDING(MAXO), .STALL_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .ex_ready(ex_ready), .flush_in(flush_in),
        .ld_done_valid(ld_done_valid), .ld_done_rd(ld_done_rd),
        .stall_out(stall_out), .bubble_out(bubble_out), .issue_out(issue_out),
        .outstanding(outstanding), .stall_cycles(stall_cycles), .error_out(error_out)
    );

    always #5 clk = ~clk;

    // Model: set of registers awaiting load data, count of x0 loads,
    // length of the current run of hazard cycles, sticky error, stall count.
    logic [31:0] mpend;
    int          mx0, mrun, mcnt;
    logic        merr;

    function automatic bit m_pending(logic [4:0] r);
        return (r != 0) && mpend[r] && !(ld_done_valid && ld_done_rd == r);
    endfunction

    function automatic int m_inflight();
        int c = mx0;
        for (int i = 0; i < 32; i++) c += int'(mpend[i]);
        return c;
    endfunction

    function automatic bit m_hit();
        if (!ld_done_valid) return 1'b0;
        if (ld_done_rd == 0) return mx0 > 0;
        return mpend[ld_done_rd];
    endfunction

    function automatic bit m_hazard();
        if (!id_valid || flush_in) return 1'b0;
        return (id_rs1_used && m_pending(id_rs1_addr)) ||
               (id_rs2_used && m_pending(id_rs2_addr)) ||
               (id_rd_we && m_pending(id_rd_addr)) ||
               (id_is_load && (m_inflight() - int'(m_hit())) == MAXO);
    endfunction

    function automatic bit m_stall();
        return m_hazard() || merr;
    endfunction

    function automatic bit m_issue();
        return id_valid && ex_ready && !m_stall() && !flush_in;
    endfunction

    function automatic logic [31:0] m_next_pend();
        logic [31:0] p = mpend;
        if (m_hit() && ld_done_rd != 0) p[ld_done_rd] = 1'b0;
        if (m_issue() && id_is_load && id_rd_addr != 0) p[id_rd_addr] = 1'b1;
        return p;
    endfunction

    function automatic int m_next_x0();
        int x = mx0;
        if (m_hit() && ld_done_rd == 0) x--;
        if (m_issue() && id_is_load && id_rd_addr == 0) x++;
        return x;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mpend <= '0;
            mx0   <= 0;
            mrun  <= 0;
            mcnt  <= 0;
            merr  <= 1'b0;
        end else begin
            mpend <= m_next_pend();
            mx0   <= m_next_x0();
            mrun  <= m_hazard() ? mrun + 1 : 0;
            if (m_hazard() && mrun + 1 >= TMO) merr <= 1'b1;
            if (m_hazard() && mcnt < (1 << CW) - 1) mcnt <= mcnt + 1;
        end
    end

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every out-of-reset cycle: DUT outputs against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_stall",       int'(stall_out),    int'(m_stall()));
            chk("m_bubble",      int'(bubble_out),   int'(m_stall()));
            chk("m_issue",       int'(issue_out),    int'(m_issue()));
            chk("m_outstanding", int'(outstanding),  m_inflight());
            chk("m_stall_cnt",   int'(stall_cycles), mcnt);
            chk("m_error",       int'(error_out),    int'(merr));
        end
    end

    task automatic ins(logic v, logic [4:0] r1, logic u1, logic [4:0] r2, logic u2,
                       logic [4:0] rd, logic we, logic ld);
        id_valid = v; id_rs1_addr = r1; id_rs1_used = u1; id_rs2_addr = r2; id_rs2_used = u2;
        id_rd_addr = rd; id_rd_we = we; id_is_load = ld;
    endtask

    task automatic done(logic v, logic [4:0] r);
        ld_done_valid = v; ld_done_rd = r;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    initial begin
        // reset with an instruction present: nothing may issue
        ins(1, 0, 0, 0, 0, 1, 1, 0);
        #3;
        chk("rst_issue", int'(issue_out), 0);
        chk("rst_stall", int'(stall_out), 0);
        chk("rst_outst", int'(outstanding), 0);
        chk("rst_err",   int'(error_out), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // load x5, then add x6,x5,x1 stalls until x5 completes
        nxt(); ins(1, 1, 1, 0, 0, 5, 1, 1); done(0, 0); samp();
        chk("ldx5_issue", int'(issue_out), 1);
        for (int k = 0; k < 3; k++) begin
            nxt(); ins(1, 5, 1, 1, 1, 6, 1, 0); samp();
            chk("use_stall",  int'(stall_out), 1);
            chk("use_bubble", int'(bubble_out), 1);
            chk("use_outst",  int'(outstanding), 1);
        end
        nxt(); done(1, 5); samp();
        chk("release_issue", int'(issue_out), 1);
        chk("release_stall", int'(stall_out), 0);
        nxt(); ins(0, 0, 0, 0, 0, 0, 0, 0); done(0, 0); samp();
        chk("x5_drained", int'(outstanding), 0);
        chk("cnt_3", int'(stall_cycles), 3);

        // two loads in flight at MAX=2, third load waits until one completes
        nxt(); ins(1, 1, 1, 0, 0, 3, 1, 1); samp();
        nxt(); ins(1, 1, 1, 0, 0, 4, 1, 1); samp();
        nxt(); ins(1, 1, 1, 0, 0, 7, 1, 1); samp();
        chk("full_stall", int'(stall_out), 1);
        chk("full_outst", int'(outstanding), 2);
        nxt(); done(1, 3); samp();
        chk("full_issue", int'(issue_out), 1);
        nxt(); ins(0, 0, 0, 0, 0, 0, 0, 0); done(1, 4); samp();
        chk("full_outst2", int'(outstanding), 2);
        nxt(); done(1, 7); samp();
        nxt(); done(0, 0); samp();
        chk("full_drained", int'(outstanding), 0);

        // load to x0 never creates a hazard but counts in flight
        nxt(); ins(1, 1, 1, 0, 0, 0, 1, 1); samp();
        nxt(); ins(1, 0, 1, 0, 1, 1, 1, 0); samp();
        chk("x0_nostall", int'(stall_out), 0);
        chk("x0_issue",   int'(issue_out), 1);
        chk("x0_outst",   int'(outstanding), 1);
        nxt(); ins(0, 0, 0, 0, 0, 0, 0, 0); done(1, 0); samp();
        nxt(); done(0, 0); samp();
        chk("x0_drained", int'(outstanding), 0);

        // spurious completion is ignored
        nxt(); done(1, 9); samp();
        nxt(); done(0, 0); samp();
        chk("spur_outst", int'(outstanding), 0);

        // ex_ready low without hazard: no issue, no stall
        nxt(); ins(1, 2, 1, 3, 1, 8, 1, 0); ex_ready = 0; samp();
        chk("exr_issue", int'(issue_out), 0);
        chk("exr_stall", int'(stall_out), 0);
        nxt(); ex_ready = 1; samp();

        // flush during stall; x5 remains pending and later use stalls again
        nxt(); ins(1, 1, 1, 0, 0, 5, 1, 1); samp();
        nxt(); ins(1, 5, 1, 1, 1, 6, 1, 0); samp();
        nxt(); samp();
        nxt(); flush_in = 1; samp();
        chk("flush_stall", int'(stall_out), 0);
        chk("flush_issue", int'(issue_out), 0);
        for (int k = 1; k <= TMO; k++) begin
            nxt(); flush_in = 0; samp();
            if (k == 1) begin
                chk("reuse_stall", int'(stall_out), 1);
                chk("reuse_outst", int'(outstanding), 1);
            end
            if (k == TMO) chk("pre_timeout_err", int'(error_out), 0);
        end
        nxt(); samp();
        chk("timeout_err",   int'(error_out), 1);
        chk("timeout_stall", int'(stall_out), 1);

        // completion in ERR: scoreboard drains, still stalled and latched
        nxt(); done(1, 5); samp();
        chk("err_done_stall", int'(stall_out), 1);
        nxt(); done(0, 0); samp();
        chk("err_sticky", int'(error_out), 1);
        chk("err_outst",  int'(outstanding), 0);

        // async reset mid-stall: load x5 cannot issue while in ERR, so use reset on held stall
        @(posedge clk); #2 rst_n = 1'b0; #1;
        chk("arst_stall", int'(stall_out), 0);
        chk("arst_issue", int'(issue_out), 0);
        chk("arst_err",   int'(error_out), 0);
        chk("arst_cnt",   int'(stall_cycles), 0);
        @(negedge clk); #2 rst_n = 1'b1;
        nxt(); samp();
        chk("post_rst_issue", int'(issue_out), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
